noc_resp_axilite_bridge: RTL and testbench
==========================================

Name: noc_resp_axilite_bridge

Overview:
- Converts OpenPiton NoC memory-response packets (NC load/store acks) into AXI-Lite R and B channel beats.
- Sits on the master side of the NoC-to-AXI-Lite path, after the request converter.
- Successor block with these additions:
  - parametrised NoC/AXI widths, multi-flit assembly, per-channel FIFO depths and endian swap;
  - a backpressured B channel with its own FIFO;
  - error responses and a counter for unknown packets.

Parameters:
- NOC_DATA_WIDTH, 64: NoC flit width.
- AXI_LITE_DATA_WIDTH, 512: RDATA width. Must be an integer multiple of NOC_DATA_WIDTH (ratio R = AXI/NOC, 1..16).
- AXI_LITE_RESP_WIDTH, 2: RRESP/BRESP width.
- R_FIFO_DEPTH, 4: R FIFO entries (power of 2, >=2).
- B_FIFO_DEPTH, 4: B FIFO entries (power of 2, >=2).
- SWAP_ENDIANESS, 0: 1 = byte-reverse each payload flit before assembly.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- noc_valid_in  in  1  flit valid.
- noc_data_in  in  NOC_DATA_WIDTH  flit.
- noc_ready_out  out  1  flit accept.
- m_axi_rdata  out  AXI_LITE_DATA_WIDTH  read data.
- m_axi_rresp  out  AXI_LITE_RESP_WIDTH  read response.
- m_axi_rvalid  out  1  R valid.
- m_axi_rready  in  1  R ready.
- m_axi_bresp  out  AXI_LITE_RESP_WIDTH  write response.
- m_axi_bvalid  out  1  B valid.
- m_axi_bready  in  1  B ready.
- drop_cnt  out  8  saturating count of discarded packets.

Interface facts:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Header fields use the `MSG_TYPE and `MSG_LENGTH defines from define.tmp.h.
- Recognised types:
  - `MSG_TYPE_NC_LOAD_MEM_ACK (8'd26)
  - `MSG_TYPE_NC_STORE_MEM_ACK (8'd27)

Behaviour:
- Reset (async assert, sync deassert), all outputs:
  - FSM = HDR; counters, drop_cnt and assembly register = 0.
  - Both FIFOs empty; rvalid = bvalid = 0; rdata = 0; rresp = bresp = 0.
  - noc_ready_out = 1.
- Reset mid-packet discards the partial packet and all FIFO contents.
- Flit handshake: go = noc_valid_in & noc_ready_out.
- FSM states: HDR, LOAD_DATA, STORE_DATA, DROP.
- HDR on go:
  - Latch len = `MSG_LENGTH and clear beat counter cnt.
  - Load ack: len = 0 pushes R {data 0, SLVERR 2'b10} and stays in HDR; else -> LOAD_DATA.
  - Store ack: len = 0 pushes B {OKAY}; else -> STORE_DATA (payload ignored).
  - Any other type: len = 0 increments drop_cnt; else -> DROP.
- LOAD_DATA on go:
  - Flit goes to assembly slot cnt (bits cnt*NOC_DATA_WIDTH upward, LSB flit first), after optional byte swap. Flits with cnt >= R are discarded.
  - On the last flit (cnt == len-1), push R with the assembled data (unfilled slots zero) and OKAY. Clear the assembly register, -> HDR.
- STORE_DATA on go: on the last flit, push B OKAY, -> HDR.
- DROP on go: on the last flit, increment drop_cnt (saturating at 255), -> HDR.
- Backpressure: noc_ready_out = 0 only when the current flit would complete a push and the target FIFO is full.
  - Non-completing flits are always accepted.
  - noc_ready_out does not depend on noc_valid_in.
- Latency: the push completes on the go edge, and rvalid/bvalid assert the next cycle (1 cycle from the final flit to valid).
- AXI channels:
  - rvalid = R FIFO not empty; bvalid = B FIFO not empty.
  - A beat pops on valid & ready. Data and resp are held stable while valid & !ready.
  - rdata/rresp read as 0 when rvalid = 0.
- A simultaneous push and pop on a full FIFO is not permitted (ready is computed from full). A push and pop on a non-full FIFO both occur.
- FIFOs are ordered per channel. The R/B channels are independent of each other, with no cross-channel ordering.

Test Plan:
- Load ack, len 8, NOC 64 / AXI 512, flits 0x11..0x88 -> one R beat 1 cycle after the last flit. rdata[63:0]=0x11 ... [511:448]=0x88, rresp=0.
- Store ack, len 0, bready=1 -> bvalid for exactly 1 cycle, the cycle after the header, bresp=0; no R activity.
- Load ack, len 0 -> R beat with rdata=0, rresp=2'b10.
- rready=0, 5 load acks of len 8, R_FIFO_DEPTH=4 -> the 5th packet's last flit stalls (noc_ready_out=0). Its first 7 flits are accepted. After one R pop, it is accepted; 5 beats then emerge in order.
- Unknown type 8'd13, len 3 -> 4 flits consumed, drop_cnt 0->1, no R/B. 300 such packets -> drop_cnt saturates at 255.
- SWAP_ENDIANESS=1, AXI=NOC=64, flit 0x0102030405060708 -> rdata 0x0807060504030201. rst_n pulsed low mid-packet -> outputs return to reset values immediately; the next packet is processed normally.

Source files
------------

// File: rtl/noc_resp_axilite_bridge_if.sv
// Bus bundle for the NoC response to AXI-Lite R/B bridge.
//
// Handshake rule for every channel here: a transfer happens on the rising
// clock edge where both valid and ready are high. The source holds data and
// valid stable until that edge, and ready never depends on valid.
interface noc_resp_axilite_bridge_if #(
  parameter int NOC_DATA_WIDTH      = 64,
  parameter int AXI_LITE_DATA_WIDTH = 512,
  parameter int AXI_LITE_RESP_WIDTH = 2
);
  logic                           noc_valid_in;
  logic [NOC_DATA_WIDTH-1:0]      noc_data_in;
  logic                           noc_ready_out;
  logic [AXI_LITE_DATA_WIDTH-1:0] m_axi_rdata;
  logic [AXI_LITE_RESP_WIDTH-1:0] m_axi_rresp;
  logic                           m_axi_rvalid;
  logic                           m_axi_rready;
  logic [AXI_LITE_RESP_WIDTH-1:0] m_axi_bresp;
  logic                           m_axi_bvalid;
  logic                           m_axi_bready;

  // Bridge side: consumes NoC flits, drives the AXI-Lite R and B channels.
  modport master (
    input  noc_valid_in, noc_data_in,
    output noc_ready_out,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );

  // Environment side: NoC flit source and AXI-Lite response sink.
  modport slave (
    output noc_valid_in, noc_data_in,
    input  noc_ready_out,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );
endinterface

// File: rtl/noc_resp_axilite_bridge.sv
// Converts OpenPiton NC load/store memory-ack packets into AXI-Lite R and B
// beats. Load payload flits are assembled LSB-flit-first into one RDATA word;
// store acks produce a B beat; unknown packets are consumed and counted.
`ifndef MSG_TYPE
`define MSG_TYPE 21:14
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_TYPE_NC_LOAD_MEM_ACK
`define MSG_TYPE_NC_LOAD_MEM_ACK 8'd26
`endif
`ifndef MSG_TYPE_NC_STORE_MEM_ACK
`define MSG_TYPE_NC_STORE_MEM_ACK 8'd27
`endif

module noc_resp_axilite_bridge #(
  parameter int NOC_DATA_WIDTH      = 64,
  parameter int AXI_LITE_DATA_WIDTH = 512,
  parameter int AXI_LITE_RESP_WIDTH = 2,
  parameter int R_FIFO_DEPTH        = 4,
  parameter int B_FIFO_DEPTH        = 4,
  parameter int SWAP_ENDIANESS      = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  noc_resp_axilite_bridge_if.master    bus,
  output logic [7:0]                   drop_cnt,
  output logic [1:0]                   dbg_state
);
  localparam int NW        = NOC_DATA_WIDTH;
  localparam int AW        = AXI_LITE_DATA_WIDTH;
  localparam int RW        = AXI_LITE_RESP_WIDTH;
  localparam int RATIO     = AW / NW;
  localparam int NOC_BYTES = NW / 8;
  localparam int R_AW      = $clog2(R_FIFO_DEPTH);
  localparam int B_AW      = $clog2(B_FIFO_DEPTH);
  localparam logic [RW-1:0] RESP_OKAY   = '0;
  localparam logic [RW-1:0] RESP_SLVERR = RW'(2);

  typedef enum logic [1:0] {
    ST_HDR        = 2'd0,
    ST_LOAD_DATA  = 2'd1,
    ST_STORE_DATA = 2'd2,
    ST_DROP       = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic [AW-1:0]   asm_q, asm_d;

  logic [7:0]      hdr_type;
  logic [7:0]      hdr_len;
  logic [NW-1:0]   flit_sw;
  logic [AW-1:0]   asm_fill;
  logic            last_beat;
  logic            r_req, b_req, drop_done;
  logic [AW-1:0]   r_push_data;
  logic [RW-1:0]   r_push_resp;
  logic            ready, go;

  logic [R_AW:0]   r_wptr_q, r_wptr_d, r_rptr_q, r_rptr_d;
  logic [B_AW:0]   b_wptr_q, b_wptr_d, b_rptr_q, b_rptr_d;
  logic [AW-1:0]   r_data_mem [R_FIFO_DEPTH];
  logic [RW-1:0]   r_resp_mem [R_FIFO_DEPTH];
  logic [RW-1:0]   b_resp_mem [B_FIFO_DEPTH];
  logic            r_empty, r_full, b_empty, b_full;
  logic            r_push, r_pop, b_push, b_pop;

  assign hdr_type  = bus.noc_data_in[`MSG_TYPE];
  assign hdr_len   = bus.noc_data_in[`MSG_LENGTH];
  assign last_beat = (cnt_q == len_q - 8'd1);

  // Optional byte reversal of the incoming payload flit.
  always_comb begin
    flit_sw = bus.noc_data_in;
    if (SWAP_ENDIANESS != 0) begin
      for (int i = 0; i < NOC_BYTES; i++) begin
        flit_sw[i*8 +: 8] = bus.noc_data_in[(NOC_BYTES-1-i)*8 +: 8];
      end
    end
  end

  // Assembly word with the current flit dropped into slot cnt; beyond R slots the flit is lost.
  always_comb begin
    asm_fill = asm_q;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt_q == 8'(i)) asm_fill[i*NW +: NW] = flit_sw;
    end
  end

  // Classify the presented flit: does it complete an R push, a B push or a drop.
  always_comb begin
    r_req       = 1'b0;
    b_req       = 1'b0;
    drop_done   = 1'b0;
    r_push_data = '0;
    r_push_resp = RESP_OKAY;
    case (state_q)
      ST_HDR: begin
        if (hdr_len == 8'd0) begin
          if (hdr_type == `MSG_TYPE_NC_LOAD_MEM_ACK) begin
            r_req       = 1'b1;
            r_push_resp = RESP_SLVERR;
          end else if (hdr_type == `MSG_TYPE_NC_STORE_MEM_ACK) begin
            b_req = 1'b1;
          end else begin
            drop_done = 1'b1;
          end
        end
      end
      ST_LOAD_DATA: begin
        r_req       = last_beat;
        r_push_data = asm_fill;
      end
      ST_STORE_DATA: b_req     = last_beat;
      ST_DROP:       drop_done = last_beat;
      default: ;
    endcase
    // Stall only a flit that would push into a full FIFO.
    ready = !(r_req && r_full) && !(b_req && b_full);
    go    = bus.noc_valid_in && ready;
  end

  // Packet FSM next-state: header decode, beat counting, assembly and drop counting.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    drop_cnt_d = drop_cnt_q;
    if (go) begin
      case (state_q)
        ST_HDR: begin
          len_d = hdr_len;
          cnt_d = 8'd0;
          if (hdr_len != 8'd0) begin
            if (hdr_type == `MSG_TYPE_NC_LOAD_MEM_ACK)       state_d = ST_LOAD_DATA;
            else if (hdr_type == `MSG_TYPE_NC_STORE_MEM_ACK) state_d = ST_STORE_DATA;
            else                                             state_d = ST_DROP;
          end
        end
        ST_LOAD_DATA: begin
          cnt_d = cnt_q + 8'd1;
          asm_d = asm_fill;
          if (last_beat) begin
            asm_d   = '0;
            state_d = ST_HDR;
          end
        end
        ST_STORE_DATA, ST_DROP: begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat) state_d = ST_HDR;
        end
        default: state_d = ST_HDR;
      endcase
      if (drop_done && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Packet FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_HDR;
      len_q      <= '0;
      cnt_q      <= '0;
      asm_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // FIFO status and pointer updates; the extra pointer bit tells full from empty.
  always_comb begin
    r_empty  = (r_wptr_q == r_rptr_q);
    r_full   = (r_wptr_q[R_AW] != r_rptr_q[R_AW]) && (r_wptr_q[R_AW-1:0] == r_rptr_q[R_AW-1:0]);
    b_empty  = (b_wptr_q == b_rptr_q);
    b_full   = (b_wptr_q[B_AW] != b_rptr_q[B_AW]) && (b_wptr_q[B_AW-1:0] == b_rptr_q[B_AW-1:0]);
    r_push   = go && r_req;
    b_push   = go && b_req;
    r_pop    = !r_empty && bus.m_axi_rready;
    b_pop    = !b_empty && bus.m_axi_bready;
    r_wptr_d = r_wptr_q + (R_AW+1)'(r_push);
    r_rptr_d = r_rptr_q + (R_AW+1)'(r_pop);
    b_wptr_d = b_wptr_q + (B_AW+1)'(b_push);
    b_rptr_d = b_rptr_q + (B_AW+1)'(b_pop);
  end

  // FIFO pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr_q <= '0;
      r_rptr_q <= '0;
      b_wptr_q <= '0;
      b_rptr_q <= '0;
    end else begin
      r_wptr_q <= r_wptr_d;
      r_rptr_q <= r_rptr_d;
      b_wptr_q <= b_wptr_d;
      b_rptr_q <= b_rptr_d;
    end
  end

  // FIFO storage; contents are masked at the outputs while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (r_push) begin
      r_data_mem[r_wptr_q[R_AW-1:0]] <= r_push_data;
      r_resp_mem[r_wptr_q[R_AW-1:0]] <= r_push_resp;
    end
    if (b_push) b_resp_mem[b_wptr_q[B_AW-1:0]] <= RESP_OKAY;
  end

  // Output drive: head-of-FIFO beats, zeroed when the channel is idle.
  always_comb begin
    bus.noc_ready_out = ready;
    bus.m_axi_rvalid  = !r_empty;
    bus.m_axi_rdata   = r_empty ? '0 : r_data_mem[r_rptr_q[R_AW-1:0]];
    bus.m_axi_rresp   = r_empty ? '0 : r_resp_mem[r_rptr_q[R_AW-1:0]];
    bus.m_axi_bvalid  = !b_empty;
    bus.m_axi_bresp   = b_empty ? '0 : b_resp_mem[b_rptr_q[B_AW-1:0]];
    drop_cnt          = drop_cnt_q;
    dbg_state         = state_q;
  end
endmodule

// File: tb/tb_noc_resp_axilite_bridge.sv
// Bench for noc_resp_axilite_bridge: a 64/512 instance with a scoreboard and
// a 64/64 byte-swapping instance for the endian path.
module tb_noc_resp_axilite_bridge;
  localparam int NW    = 64;
  localparam int AW    = 512;
  localparam int RW    = 2;
  localparam int RATIO = AW / NW;
  localparam int TYPE_LSB = 14;
  localparam int LEN_LSB  = 22;
  localparam logic [7:0]    T_LOAD   = 8'd26;
  localparam logic [7:0]    T_STORE  = 8'd27;
  localparam logic [RW-1:0] R_OKAY   = 2'b00;
  localparam logic [RW-1:0] R_SLVERR = 2'b10;

  typedef logic [NW-1:0] flit_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_resp_axilite_bridge_if #(.NOC_DATA_WIDTH(NW), .AXI_LITE_DATA_WIDTH(AW), .AXI_LITE_RESP_WIDTH(RW)) bus ();
  noc_resp_axilite_bridge_if #(.NOC_DATA_WIDTH(NW), .AXI_LITE_DATA_WIDTH(NW), .AXI_LITE_RESP_WIDTH(RW)) sbus ();

  logic [7:0] drop_cnt, s_drop_cnt;
  logic [1:0] dbg_state, s_dbg_state;

  noc_resp_axilite_bridge #(
    .NOC_DATA_WIDTH(NW), .AXI_LITE_DATA_WIDTH(AW), .AXI_LITE_RESP_WIDTH(RW),
    .R_FIFO_DEPTH(4), .B_FIFO_DEPTH(4), .SWAP_ENDIANESS(0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  noc_resp_axilite_bridge #(
    .NOC_DATA_WIDTH(NW), .AXI_LITE_DATA_WIDTH(NW), .AXI_LITE_RESP_WIDTH(RW),
    .R_FIFO_DEPTH(4), .B_FIFO_DEPTH(4), .SWAP_ENDIANESS(1)
  ) u_swap (
    .clk(clk), .rst_n(rst_n), .bus(sbus), .drop_cnt(s_drop_cnt), .dbg_state(s_dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int last_wait = 0;
  int model_drop = 0;
  bit mon_en = 1'b0;
  bit rand_bp = 1'b0;
  logic [RW+AW-1:0] exp_r_q[$];
  logic [RW-1:0]    exp_b_q[$];

  // ---------------- scoreboard monitor (samples 2 ns after the falling edge)
  initial begin
    logic [RW+AW-1:0] e;
    logic [RW-1:0]    eb;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && rst_n) begin
        if (bus.m_axi_rvalid && bus.m_axi_rready) begin
          n_checks++;
          if (exp_r_q.size() == 0) begin
            n_fail++;
            $display("FAIL r_unexpected: got rresp=%0d rdata=%h, expected no beat", bus.m_axi_rresp, bus.m_axi_rdata);
          end else begin
            e = exp_r_q.pop_front();
            if ({bus.m_axi_rresp, bus.m_axi_rdata} !== e) begin
              n_fail++;
              $display("FAIL r_beat: got rresp=%0d rdata=%h, expected rresp=%0d rdata=%h",
                       bus.m_axi_rresp, bus.m_axi_rdata, e[RW+AW-1:AW], e[AW-1:0]);
            end
          end
        end
        if (!bus.m_axi_rvalid) begin
          n_checks++;
          if (bus.m_axi_rdata !== '0 || bus.m_axi_rresp !== '0) begin
            n_fail++;
            $display("FAIL r_idle_zero: got rresp=%0d rdata=%h, expected 0", bus.m_axi_rresp, bus.m_axi_rdata);
          end
        end
        if (bus.m_axi_bvalid && bus.m_axi_bready) begin
          n_checks++;
          if (exp_b_q.size() == 0) begin
            n_fail++;
            $display("FAIL b_unexpected: got bresp=%0d, expected no beat", bus.m_axi_bresp);
          end else begin
            eb = exp_b_q.pop_front();
            if (bus.m_axi_bresp !== eb) begin
              n_fail++;
              $display("FAIL b_beat: got bresp=%0d, expected %0d", bus.m_axi_bresp, eb);
            end
          end
        end
      end
    end
  end

  // ---------------- random AXI backpressure
  initial forever begin
    @(negedge clk);
    if (rand_bp) begin
      bus.m_axi_rready = ($urandom_range(0, 3) != 0);
      bus.m_axi_bready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- watchdog
  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers
  function automatic flit_q_t rand_flits(input int n);
    flit_q_t q;
    for (int i = 0; i < n; i++) q.push_back({$urandom, $urandom});
    return q;
  endfunction

  function automatic logic [NW-1:0] make_hdr(input logic [7:0] typ, input int len);
    logic [NW-1:0] h;
    h = {$urandom, $urandom};
    h[TYPE_LSB +: 8] = typ;
    h[LEN_LSB +: 8]  = 8'(len);
    return h;
  endfunction

  // Reference model: what one packet should produce on R, B or the drop counter.
  task automatic model_expect(input logic [7:0] typ, input int len, input flit_q_t fl);
    logic [AW-1:0] d;
    if (typ == T_LOAD) begin
      if (len == 0) exp_r_q.push_back({R_SLVERR, {AW{1'b0}}});
      else begin
        d = '0;
        for (int i = 0; i < len && i < RATIO; i++) d[i*NW +: NW] = fl[i];
        exp_r_q.push_back({R_OKAY, d});
      end
    end else if (typ == T_STORE) begin
      exp_b_q.push_back(R_OKAY);
    end else if (model_drop < 255) begin
      model_drop++;
    end
  endtask

  task automatic send_flit(input logic [NW-1:0] d);
    int t;
    t = 0;
    @(negedge clk);
    bus.noc_valid_in = 1'b1;
    bus.noc_data_in  = d;
    #1;
    while (bus.noc_ready_out !== 1'b1 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    last_wait = t;
    n_checks++;
    if (bus.noc_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL flit_accept: noc_ready_out=%b after %0d cycles, expected 1", bus.noc_ready_out, t);
    end else begin
      @(posedge clk);
    end
    #1 bus.noc_valid_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] typ, input int len, input flit_q_t fl);
    model_expect(typ, len, fl);
    send_flit(make_hdr(typ, len));
    for (int i = 0; i < len; i++) send_flit(fl[i]);
  endtask

  task automatic send_sflit(input logic [NW-1:0] d);
    int t;
    t = 0;
    @(negedge clk);
    sbus.noc_valid_in = 1'b1;
    sbus.noc_data_in  = d;
    #1;
    while (sbus.noc_ready_out !== 1'b1 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    n_checks++;
    if (sbus.noc_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL sflit_accept: noc_ready_out=%b, expected 1", sbus.noc_ready_out);
    end else begin
      @(posedge clk);
    end
    #1 sbus.noc_valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_r_q.size() != 0 || exp_b_q.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    #3;
    n_checks++;
    if (exp_r_q.size() != 0 || exp_b_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d R and %0d B beats outstanding, expected 0", exp_r_q.size(), exp_b_q.size());
    end
    n_checks++;
    if (bus.m_axi_rvalid !== 1'b0 || bus.m_axi_bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle: rvalid=%b bvalid=%b, expected 0 0", bus.m_axi_rvalid, bus.m_axi_bvalid);
    end
  endtask

  // ---------------- tests
  task automatic test_reset();
    #12;
    n_checks++;
    if (bus.m_axi_rvalid !== 1'b0 || bus.m_axi_bvalid !== 1'b0 || bus.m_axi_rdata !== '0 ||
        bus.m_axi_rresp !== '0 || bus.m_axi_bresp !== '0 || bus.noc_ready_out !== 1'b1 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_values: rv=%b bv=%b rresp=%0d bresp=%0d rdy=%b drop=%0d, expected 0 0 0 0 1 0",
               bus.m_axi_rvalid, bus.m_axi_bvalid, bus.m_axi_rresp, bus.m_axi_bresp, bus.noc_ready_out, drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.noc_ready_out !== 1'b1 || bus.m_axi_rvalid !== 1'b0 || sbus.noc_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: rdy=%b rv=%b srdy=%b, expected 1 0 1", bus.noc_ready_out, bus.m_axi_rvalid, sbus.noc_ready_out);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_load_len8();
    flit_q_t fl;
    for (int i = 0; i < 8; i++) fl.push_back(NW'(32'h11 * (i + 1)));
    bus.m_axi_rready = 1'b1;
    send_pkt(T_LOAD, 8, fl);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.m_axi_rvalid !== 1'b1 || bus.m_axi_rresp !== R_OKAY ||
        bus.m_axi_rdata[63:0] !== 64'h11 || bus.m_axi_rdata[511:448] !== 64'h88) begin
      n_fail++;
      $display("FAIL load8_beat: rv=%b rresp=%0d lo=%h hi=%h, expected 1 0 11 88",
               bus.m_axi_rvalid, bus.m_axi_rresp, bus.m_axi_rdata[63:0], bus.m_axi_rdata[511:448]);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.m_axi_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL load8_single: rvalid=%b one cycle later, expected 0", bus.m_axi_rvalid);
    end
    wait_drain();
  endtask

  task automatic test_store_len0();
    flit_q_t fl;
    bus.m_axi_bready = 1'b1;
    send_pkt(T_STORE, 0, fl);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.m_axi_bvalid !== 1'b1 || bus.m_axi_bresp !== R_OKAY || bus.m_axi_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL store0_beat: bv=%b bresp=%0d rv=%b, expected 1 0 0", bus.m_axi_bvalid, bus.m_axi_bresp, bus.m_axi_rvalid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.m_axi_bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL store0_single: bvalid=%b one cycle later, expected 0", bus.m_axi_bvalid);
    end
    wait_drain();
  endtask

  task automatic test_load_len0();
    flit_q_t fl;
    send_pkt(T_LOAD, 0, fl);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.m_axi_rvalid !== 1'b1 || bus.m_axi_rresp !== R_SLVERR || bus.m_axi_rdata !== '0) begin
      n_fail++;
      $display("FAIL load0_err: rv=%b rresp=%0d rdata_nonzero=%b, expected 1 2 0",
               bus.m_axi_rvalid, bus.m_axi_rresp, |bus.m_axi_rdata);
    end
    wait_drain();
  endtask

  task automatic test_drop();
    send_pkt(8'd13, 3, rand_flits(3));
    @(negedge clk);
    #1;
    n_checks++;
    if (drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_one: drop_cnt=%0d, expected 1", drop_cnt);
    end
    for (int p = 1; p < 300; p++) send_pkt(8'd13, 3, rand_flits(3));
    @(negedge clk);
    #1;
    n_checks++;
    if (drop_cnt !== 8'(model_drop) || model_drop != 255) begin
      n_fail++;
      $display("FAIL drop_saturate: drop_cnt=%0d, expected %0d (255)", drop_cnt, model_drop);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    flit_q_t fl;
    bus.m_axi_rready = 1'b0;
    for (int p = 0; p < 4; p++) send_pkt(T_LOAD, 8, rand_flits(8));
    fl = rand_flits(8);
    model_expect(T_LOAD, 8, fl);
    send_flit(make_hdr(T_LOAD, 8));
    for (int i = 0; i < 7; i++) begin
      send_flit(fl[i]);
      n_checks++;
      if (last_wait != 0) begin
        n_fail++;
        $display("FAIL bp_early_stall: flit %0d waited %0d cycles, expected 0", i, last_wait);
      end
    end
    @(negedge clk);
    bus.noc_valid_in = 1'b1;
    bus.noc_data_in  = fl[7];
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (bus.noc_ready_out !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall: noc_ready_out=%b with R FIFO full, expected 0", bus.noc_ready_out);
      end
      @(negedge clk);
    end
    bus.m_axi_rready = 1'b1;
    @(posedge clk);
    #1 bus.m_axi_rready = 1'b0;
    n_checks++;
    if (bus.noc_ready_out !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: noc_ready_out=%b after one pop, expected 1", bus.noc_ready_out);
    end
    @(posedge clk);
    #1 bus.noc_valid_in = 1'b0;
    @(negedge clk);
    bus.m_axi_rready = 1'b1;
    wait_drain();
  endtask

  task automatic test_random();
    logic [7:0] typ;
    int len;
    rand_bp = 1'b1;
    for (int p = 0; p < 60; p++) begin
      case ($urandom_range(0, 2))
        0: typ = T_LOAD;
        1: typ = T_STORE;
        default: begin
          typ = 8'($urandom_range(0, 255));
          while (typ == T_LOAD || typ == T_STORE) typ = 8'($urandom_range(0, 255));
        end
      endcase
      len = $urandom_range(0, 12);
      send_pkt(typ, len, rand_flits(len));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    rand_bp = 1'b0;
    bus.m_axi_rready = 1'b1;
    bus.m_axi_bready = 1'b1;
    wait_drain();
    n_checks++;
    if (drop_cnt !== 8'(model_drop)) begin
      n_fail++;
      $display("FAIL random_drop: drop_cnt=%0d, expected %0d", drop_cnt, model_drop);
    end
  endtask

  task automatic test_swap();
    logic [NW-1:0] f, e;
    f = 64'h0102030405060708;
    send_sflit(make_hdr(T_LOAD, 1));
    send_sflit(f);
    @(negedge clk);
    #1;
    n_checks++;
    if (sbus.m_axi_rvalid !== 1'b1 || sbus.m_axi_rdata !== 64'h0807060504030201 || sbus.m_axi_rresp !== R_OKAY) begin
      n_fail++;
      $display("FAIL swap_fixed: rv=%b rdata=%h rresp=%0d, expected 1 0807060504030201 0",
               sbus.m_axi_rvalid, sbus.m_axi_rdata, sbus.m_axi_rresp);
    end
    // Two payload flits with R = 1: only the first one lands in RDATA.
    f = {$urandom, $urandom};
    e = {<<8{f}};
    send_sflit(make_hdr(T_LOAD, 2));
    send_sflit(f);
    send_sflit({$urandom, $urandom});
    @(negedge clk);
    #1;
    n_checks++;
    if (sbus.m_axi_rvalid !== 1'b1 || sbus.m_axi_rdata !== e) begin
      n_fail++;
      $display("FAIL swap_random: rv=%b rdata=%h, expected 1 %h", sbus.m_axi_rvalid, sbus.m_axi_rdata, e);
    end
  endtask

  task automatic test_reset_mid();
    flit_q_t fl;
    bus.m_axi_rready = 1'b0;
    send_pkt(T_LOAD, 0, fl);
    send_flit(make_hdr(T_LOAD, 8));
    for (int i = 0; i < 3; i++) send_flit({$urandom, $urandom});
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.m_axi_rvalid !== 1'b0 || bus.m_axi_rdata !== '0 || bus.m_axi_rresp !== '0 ||
        bus.m_axi_bvalid !== 1'b0 || bus.noc_ready_out !== 1'b1 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid: rv=%b rresp=%0d bv=%b rdy=%b drop=%0d, expected 0 0 0 1 0",
               bus.m_axi_rvalid, bus.m_axi_rresp, bus.m_axi_bvalid, bus.noc_ready_out, drop_cnt);
    end
    exp_r_q.delete();
    exp_b_q.delete();
    model_drop = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.m_axi_rready = 1'b1;
    send_pkt(T_LOAD, 8, rand_flits(8));
    send_pkt(T_STORE, 2, rand_flits(2));
    send_pkt(T_LOAD, 5, rand_flits(5));
    wait_drain();
    n_checks++;
    if (drop_cnt !== 8'(model_drop)) begin
      n_fail++;
      $display("FAIL reset_mid_drop: drop_cnt=%0d, expected %0d", drop_cnt, model_drop);
    end
  endtask

  initial begin
    bus.noc_valid_in  = 1'b0;
    bus.noc_data_in   = '0;
    bus.m_axi_rready  = 1'b1;
    bus.m_axi_bready  = 1'b1;
    sbus.noc_valid_in = 1'b0;
    sbus.noc_data_in  = '0;
    sbus.m_axi_rready = 1'b1;
    sbus.m_axi_bready = 1'b1;
    test_reset();
    test_load_len8();
    test_store_len0();
    test_load_len0();
    test_drop();
    test_backpressure();
    test_random();
    test_swap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
